pc_redirect_sequencer: RTL and testbench

Multicycle sequencer that owns every non-sequential PC update in the processor datapath. It drives the PC-source select, PC write enable and EPC write enable, and walks exception entry through EPC save, vector-address read and handler load. The main control unit issues jump, branch, register-jump and return-from-exception requests over a valid/ready handshake. Exceptions arrive on a separate, higher-priority input.

---
 rtl/pc_redirect_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_pc_redirect_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_sequencer.sv
// pc_redirect_sequencer
//
// Multicycle sequencer for every non-sequential PC update. It accepts
// jump / beq / bne / jr / rte requests from the main control unit and runs
// exception entry: save EPC, read the vector byte, wait for memory, then load
// the handler address into the PC.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is combinational and is high only in
// IDLE with no latched exception and no exc_valid, because exceptions always
// win over requests. While req_ready is low the control side must hold the
// request.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   req_valid     redirect request from control
//   req_op        000 jump, 001 beq, 010 bne, 011 jr, 100 rte, others illegal
//   alu_zero      ALU zero flag, captured when the request transfers
//   req_ready     request transfers this edge if req_valid is high
//   exc_valid     exception raised
//   exc_code      00 invalid opcode, 01 overflow, 10 divide by zero, 11 as 00
//   PCsource      PC mux select: 000 jump, 001 EPC, 010 memory, 011 ALU_out
//   PCWrite       PC load enable
//   EPCWrite      EPC load enable
//   epc_alu_req   ALU asked to produce PC-4
//   exc_mem_read  read of the vector byte
//   exc_vec_addr  vector address 0xFD / 0xFE / 0xFF of the last exception
//   exc_pending   an exception is latched awaiting service
//   done          one-cycle pulse when a redirect completes
//   dbg_state     current state: 0 IDLE, 1 EXEC, 2 EXC_SAVE, 3 EXC_READ,
//                 4 EXC_WAIT, 5 EXC_LOAD
module pc_redirect_sequencer #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  input  logic       alu_zero,
  output logic       req_ready,
  input  logic       exc_valid,
  input  logic [1:0] exc_code,
  output logic [2:0] PCsource,
  output logic       PCWrite,
  output logic       EPCWrite,
  output logic       epc_alu_req,
  output logic       exc_mem_read,
  output logic [7:0] exc_vec_addr,
  output logic       exc_pending,
  output logic       done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_EXC_SAVE = 3'd2,
    S_EXC_READ = 3'd3,
    S_EXC_WAIT = 3'd4,
    S_EXC_LOAD = 3'd5
  } state_t;

  localparam logic [2:0] OP_JUMP = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_JR   = 3'b011;
  localparam logic [2:0] OP_RTE  = 3'b100;

  localparam logic [2:0] SRC_JUMP = 3'b000;
  localparam logic [2:0] SRC_EPC  = 3'b001;
  localparam logic [2:0] SRC_MEM  = 3'b010;
  localparam logic [2:0] SRC_ALU  = 3'b011;

  localparam logic [7:0] VEC_BASE = 8'hFD;

  // EXC_WAIT lasts MEM_LATENCY cycles: the counter is loaded with
  // MEM_LATENCY-1 in EXC_READ and the wait ends when it reads zero.
  localparam bit         HAS_WAIT  = (MEM_LATENCY != 0);
  localparam logic [3:0] WAIT_INIT = 4'((MEM_LATENCY == 0) ? 0 : MEM_LATENCY - 1);

  state_t     state;
  state_t     state_next;
  logic [2:0] op_q;
  logic       zero_q;
  logic       pend_q;
  logic [1:0] pend_code_q;
  logic [7:0] vec_q;
  logic [3:0] cnt_q;
  logic       op_legal;
  logic       take_pend;
  logic       take_exc;
  logic       take_req;

  // Code 11 is serviced like an invalid opcode.
  function automatic logic [7:0] vec_of(input logic [1:0] code);
    return (code == 2'b11) ? VEC_BASE : VEC_BASE + {6'd0, code};
  endfunction

  assign op_legal  = (op_q <= OP_RTE);
  assign take_pend = (state == S_IDLE) && pend_q;
  assign take_exc  = (state == S_IDLE) && !pend_q && exc_valid;
  assign take_req  = (state == S_IDLE) && !pend_q && !exc_valid && req_valid;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (pend_q || exc_valid) state_next = S_EXC_SAVE;
        else if (req_valid)      state_next = S_EXEC;
      end
      // An illegal op turns into an invalid-opcode exception.
      S_EXEC:     state_next = op_legal ? S_IDLE : S_EXC_SAVE;
      S_EXC_SAVE: state_next = S_EXC_READ;
      S_EXC_READ: state_next = HAS_WAIT ? S_EXC_WAIT : S_EXC_LOAD;
      S_EXC_WAIT: if (cnt_q == 4'd0) state_next = S_EXC_LOAD;
      S_EXC_LOAD: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Captured request, pending exception, vector address and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= OP_JUMP;
      zero_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_code_q <= 2'b00;
      vec_q       <= VEC_BASE;
      cnt_q       <= 4'd0;
    end else begin
      if (take_req) begin
        op_q   <= req_op;
        zero_q <= alu_zero;
      end

      if (take_pend) begin
        pend_q <= 1'b0;
        vec_q  <= vec_of(pend_code_q);
      end else if (take_exc) begin
        vec_q <= vec_of(exc_code);
      end

      // During a legal EXEC an exception is parked; the first one wins.
      // An illegal op already enters exception service, so exc_valid
      // arriving alongside it is dropped like any nested exception.
      if (state == S_EXEC) begin
        if (!op_legal) begin
          vec_q <= VEC_BASE;
        end else if (exc_valid && !pend_q) begin
          pend_q      <= 1'b1;
          pend_code_q <= exc_code;
        end
      end

      if (state == S_EXC_READ)                         cnt_q <= WAIT_INIT;
      else if (state == S_EXC_WAIT && cnt_q != 4'd0)   cnt_q <= cnt_q - 4'd1;
    end
  end

  // Output logic
  always_comb begin
    PCsource     = SRC_JUMP;
    PCWrite      = 1'b0;
    EPCWrite     = 1'b0;
    epc_alu_req  = 1'b0;
    exc_mem_read = 1'b0;
    done         = 1'b0;
    req_ready    = (state == S_IDLE) && !pend_q && !exc_valid;
    unique case (state)
      S_EXEC: begin
        if (op_legal) begin
          done = 1'b1;
          unique case (op_q)
            OP_JUMP: begin PCsource = SRC_JUMP; PCWrite = 1'b1;    end
            OP_BEQ:  begin PCsource = SRC_ALU;  PCWrite = zero_q;  end
            OP_BNE:  begin PCsource = SRC_ALU;  PCWrite = !zero_q; end
            OP_JR:   begin PCsource = SRC_ALU;  PCWrite = 1'b1;    end
            OP_RTE:  begin PCsource = SRC_EPC;  PCWrite = 1'b1;    end
            default: begin PCsource = SRC_JUMP; PCWrite = 1'b0;    end
          endcase
        end
      end
      S_EXC_SAVE: begin
        epc_alu_req = 1'b1;
        EPCWrite    = 1'b1;
      end
      S_EXC_READ: exc_mem_read = 1'b1;
      S_EXC_LOAD: begin
        PCsource = SRC_MEM;
        PCWrite  = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign exc_vec_addr = vec_q;
  assign exc_pending  = pend_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Testbench for pc_redirect_sequencer (MEM_LATENCY = 2).
// The reference model schedules, at the moment a request or exception is
// taken, the exact per-cycle output pattern the redirect must produce and
// replays it cycle by cycle against the DUT.
module tb_pc_redirect_sequencer;

  localparam int unsigned LAT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_op = 3'd0;
  logic       alu_zero = 1'b0;
  logic       req_ready;
  logic       exc_valid = 1'b0;
  logic [1:0] exc_code = 2'd0;
  logic [2:0] PCsource;
  logic       PCWrite;
  logic       EPCWrite;
  logic       epc_alu_req;
  logic       exc_mem_read;
  logic [7:0] exc_vec_addr;
  logic       exc_pending;
  logic       done;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle expectation record:
  // [17] legal EXEC cycle, [16] vector changes, [15:8] vector,
  // [7:5] PCsource, [4] PCWrite, [3] EPCWrite, [2] epc_alu_req,
  // [1] exc_mem_read, [0] done
  logic [17:0] exp_q[$];
  logic        pending = 1'b0;
  logic [1:0]  pend_code = 2'd0;
  logic [7:0]  model_vec = 8'hFD;

  pc_redirect_sequencer #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .alu_zero(alu_zero),
    .req_ready(req_ready),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .PCsource(PCsource), .PCWrite(PCWrite), .EPCWrite(EPCWrite),
    .epc_alu_req(epc_alu_req), .exc_mem_read(exc_mem_read),
    .exc_vec_addr(exc_vec_addr), .exc_pending(exc_pending),
    .done(done), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk(input logic ok, input logic hv, input logic [7:0] v,
                                     input logic [2:0] src, input logic pcw, input logic epcw,
                                     input logic alu, input logic mrd, input logic dn);
    return {ok, hv, v, src, pcw, epcw, alu, mrd, dn};
  endfunction

  // Exception service: save, read, LAT wait cycles, load.
  task automatic push_exc(input logic [1:0] code);
    logic [7:0] v;
    v = (code == 2'd3) ? 8'hFD : 8'hFD + 8'(code);
    exp_q.push_back(mk(1'b0, 1'b1, v, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < int'(LAT); i++)
      exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic push_exec(input logic [2:0] op, input logic z);
    case (op)
      3'd0: exp_q.push_back(mk(1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      3'd1: exp_q.push_back(mk(1'b1, 1'b0, 8'h00, 3'd3, z,    1'b0, 1'b0, 1'b0, 1'b1));
      3'd2: exp_q.push_back(mk(1'b1, 1'b0, 8'h00, 3'd3, !z,   1'b0, 1'b0, 1'b0, 1'b1));
      3'd3: exp_q.push_back(mk(1'b1, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      3'd4: exp_q.push_back(mk(1'b1, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      default: begin
        exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push_exc(2'd0);
      end
    endcase
  endtask

  task automatic check_quiet(input logic exp_ready);
    check("pcsource", 32'(PCsource), 32'd0);
    check("pcwrite", 32'(PCWrite), 32'd0);
    check("epcwrite", 32'(EPCWrite), 32'd0);
    check("epc_alu_req", 32'(epc_alu_req), 32'd0);
    check("mem_read", 32'(exc_mem_read), 32'd0);
    check("done", 32'(done), 32'd0);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("idle_state", 32'(dbg_state == 3'd0), 32'd1);
  endtask

  // Driver: one clock cycle. Called at posedge+1; inputs are applied,
  // outputs compared at the negedge, then the model consumes the cycle.
  task automatic step(input logic rv, input logic [2:0] op, input logic z,
                      input logic ev, input logic [1:0] code);
    logic [17:0] r;
    req_valid = rv; req_op = op; alu_zero = z; exc_valid = ev; exc_code = code;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      if (r[16]) model_vec = r[15:8];
      check("pcsource", 32'(PCsource), 32'(r[7:5]));
      check("pcwrite", 32'(PCWrite), 32'(r[4]));
      check("epcwrite", 32'(EPCWrite), 32'(r[3]));
      check("epc_alu_req", 32'(epc_alu_req), 32'(r[2]));
      check("mem_read", 32'(exc_mem_read), 32'(r[1]));
      check("done", 32'(done), 32'(r[0]));
      check("req_ready_busy", 32'(req_ready), 32'd0);
      check("exc_pending", 32'(exc_pending), 32'(pending));
      check("vec_addr", 32'(exc_vec_addr), 32'(model_vec));
      if (r[17] && ev && !pending) begin
        pending   = 1'b1;
        pend_code = code;
      end
    end else begin
      check_quiet(!pending && !ev);
      check("exc_pending", 32'(exc_pending), 32'(pending));
      check("vec_addr", 32'(exc_vec_addr), 32'(model_vec));
      if (pending) begin
        push_exc(pend_code);
        pending = 1'b0;
      end else if (ev) begin
        push_exc(code);
      end else if (rv) begin
        push_exec(op, z);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 1'b0, 2'd0);
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic reset_mid();
    req_valid = 1'b0; exc_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_quiet(1'b1);
    check("rst_pending", 32'(exc_pending), 32'd0);
    check("rst_vec", 32'(exc_vec_addr), 32'hFD);
    exp_q.delete();
    pending   = 1'b0;
    model_vec = 8'hFD;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_quiet(1'b1);
    check("rst_pending", 32'(exc_pending), 32'd0);
    check("rst_vec", 32'(exc_vec_addr), 32'hFD);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // jump, then beq/bne with zero clear
    step(1'b1, 3'd0, 1'b0, 1'b0, 2'd0);
    idle(2);
    step(1'b1, 3'd1, 1'b0, 1'b0, 2'd0);
    idle(1);
    step(1'b1, 3'd2, 1'b0, 1'b0, 2'd0);
    idle(2);
    // overflow exception
    step(1'b0, 3'd0, 1'b0, 1'b1, 2'd1);
    idle(6);
    // divide-by-zero during jr EXEC, invalid-opcode one cycle later dropped
    step(1'b1, 3'd3, 1'b0, 1'b0, 2'd0);
    step(1'b0, 3'd0, 1'b0, 1'b1, 2'd2);
    step(1'b0, 3'd0, 1'b0, 1'b1, 2'd0);
    idle(7);
    // rte competing with exception code 11; control holds rte until taken
    for (int i = 0; i < 8; i++) step(1'b1, 3'd4, 1'b0, (i == 0), 2'd3);
    idle(2);
    // reset while waiting on memory
    step(1'b0, 3'd0, 1'b0, 1'b1, 2'd1);
    idle(2);
    reset_mid();
    idle(4);
    // illegal op
    step(1'b1, 3'd6, 1'b0, 1'b0, 2'd0);
    idle(8);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) reset_mid();
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)));
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
